// File: rtl/led_axi_sequencer_if.sv
// AXI4-Lite write-only channel bundle (AW/W/B) between the LED sequencer and the
// LED register slave. There is no read channel.
interface led_axi_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/led_axi_sequencer.sv
// AXI4-Lite write-only master that steps an incrementing pattern into the LED
// register, one AW/W/B transaction per value, with a programmable idle gap.
//
// state | meaning
// IDLE  | waiting for i_start; all channels quiet
// XFER  | AWVALID/WVALID raised, each dropped on its own handshake
// RESP  | BREADY high, waiting for the write response
// WAIT  | idle gap of INTERVAL cycles before the next value
module led_axi_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] TARGET_ADDR        = '0,
    parameter logic [31:0]                   PATTERN_LAST       = 32'd15,
    parameter int unsigned                   INTERVAL           = 100
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [31:0]         o_value,
    led_axi_sequencer_if.master m_axi
);

    localparam int              CNT_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      next_value;
    logic             last_step;
    logic             aw_fin;
    logic             w_fin;

    assign next_value = (o_value == PATTERN_LAST) ? 32'd0 : o_value + 32'd1;
    assign last_step  = i_stop || ((o_value == PATTERN_LAST) && !i_loop);

    // A channel counts as finished if it already handshook or handshakes this edge.
    assign aw_fin = !m_axi.awvalid || m_axi.awready;
    assign w_fin  = !m_axi.wvalid  || m_axi.wready;

    assign m_axi.awaddr = TARGET_ADDR;
    assign m_axi.awprot = 3'b000;
    assign m_axi.wdata  = o_value;
    assign m_axi.wstrb  = '1;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cnt           <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_value       <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        o_err         <= 1'b0;
                        o_value       <= '0;
                        o_busy        <= 1'b1;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wvalid  <= 1'b1;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
                    if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        m_axi.bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi.bvalid && m_axi.bready) begin
                        m_axi.bready <= 1'b0;
                        if (m_axi.bresp != 2'b00) o_err <= 1'b1;
                        if (last_step) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= IDLE;
                        end else if (INTERVAL == 0) begin
                            o_value       <= next_value;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state         <= XFER;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_stop) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end else if (cnt == '0) begin
                        o_value       <= next_value;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wvalid  <= 1'b1;
                        state         <= XFER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_axi_sequencer.sv
// Bench for led_axi_sequencer: a delay-programmable slave on an INTERVAL=2 instance
// and an always-ready slave on an INTERVAL=0 instance, checked against pattern rules.
module tb_led_axi_sequencer;
    localparam int LAST = 15;
    localparam int GAP_A = 2 + 1;  // B handshake edge to first sample of AWVALID high
    localparam int GAP_B = 0 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- instance A: INTERVAL=2, programmable slave ----------------
    logic start_a = 0, stop_a = 0, loop_a = 0;
    logic busy_a, done_a, err_a;
    logic [31:0] value_a;
    led_axi_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
    led_axi_sequencer #(.TARGET_ADDR(32'h0), .PATTERN_LAST(32'd15), .INTERVAL(2)) dut_a (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .i_start(start_a), .i_stop(stop_a), .i_loop(loop_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_value(value_a),
        .m_axi(bus_a)
    );

    int aw_dly = 0, w_dly = 0, b_dly = 0, err_abs = -1;
    bit rnd = 0;
    int cur_aw = 0, cur_w = 0, cur_b = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    int naw_a = 0, nw_a = 0, nb_a = 0, nerr_a = 0;
    logic bvalid_a_r = 0;
    logic [1:0] bresp_a_r = 2'b00;
    logic [31:0] wd_a[$];

    assign bus_a.awready = bus_a.awvalid && (aw_wait >= cur_aw);
    assign bus_a.wready  = bus_a.wvalid && (w_wait >= cur_w);
    assign bus_a.bvalid  = bvalid_a_r;
    assign bus_a.bresp   = bresp_a_r;

    always @(posedge clk) begin
        if (!rst_n) begin
            naw_a <= nb_a;
            nw_a <= nb_a;
            bvalid_a_r <= 1'b0;
            aw_wait <= 0;
            w_wait <= 0;
            b_wait <= 0;
        end else begin
            if (!bus_a.awvalid) begin
                aw_wait <= 0;
                cur_aw <= rnd ? int'($urandom_range(0, 4)) : aw_dly;
            end else if (!bus_a.awready) aw_wait <= aw_wait + 1;
            else naw_a <= naw_a + 1;
            if (!bus_a.wvalid) begin
                w_wait <= 0;
                cur_w <= rnd ? int'($urandom_range(0, 4)) : w_dly;
            end else if (!bus_a.wready) w_wait <= w_wait + 1;
            else begin
                nw_a <= nw_a + 1;
                wd_a.push_back(bus_a.wdata);
            end
            if (bvalid_a_r && bus_a.bready) begin
                bvalid_a_r <= 1'b0;
                nb_a <= nb_a + 1;
                b_wait <= 0;
                if (bresp_a_r != 2'b00) nerr_a <= nerr_a + 1;
            end else if (!bvalid_a_r && naw_a > nb_a && nw_a > nb_a) begin
                if (b_wait >= cur_b) begin
                    bvalid_a_r <= 1'b1;
                    bresp_a_r <= ((nb_a == err_abs) || (rnd && $urandom_range(0, 7) == 0)) ? 2'b10 : 2'b00;
                end else b_wait <= b_wait + 1;
            end else if (!bvalid_a_r) begin
                b_wait <= 0;
                cur_b <= rnd ? int'($urandom_range(0, 6)) : b_dly;
            end
        end
    end

    // protocol / timing monitor for A
    int cyc = 0, viol_a = 0, ndone_a = 0, b_cyc_a = 0;
    bit prev_rst = 0, pend_aw = 0, pend_w = 0, prev_awv_a = 0, have_b_a = 0, prev_done_a = 0;
    int gaps_a[$];
    always @(posedge clk) begin : mon_a
        int v;
        v = 0;
        cyc <= cyc + 1;
        if (rst_n && prev_rst) begin
            if (pend_aw && !bus_a.awvalid) v++;
            if (pend_w && !bus_a.wvalid) v++;
            if (bus_a.bready && (bus_a.awvalid || bus_a.wvalid)) v++;
            if (bus_a.awvalid && (bus_a.awaddr != 32'h0 || bus_a.awprot != 3'b000)) v++;
            if (bus_a.wvalid && (bus_a.wstrb != 4'hF || bus_a.wdata != value_a)) v++;
            if (done_a && prev_done_a) v++;
        end
        viol_a <= viol_a + v;
        if (done_a) ndone_a <= ndone_a + 1;
        if (bus_a.awvalid && !prev_awv_a && have_b_a) gaps_a.push_back(cyc - b_cyc_a);
        if (bus_a.bvalid && bus_a.bready) begin
            have_b_a <= 1;
            b_cyc_a <= cyc;
        end else if (!busy_a || (bus_a.awvalid && !prev_awv_a)) have_b_a <= 0;
        prev_rst <= rst_n;
        pend_aw <= bus_a.awvalid && !bus_a.awready;
        pend_w <= bus_a.wvalid && !bus_a.wready;
        prev_awv_a <= bus_a.awvalid;
        prev_done_a <= done_a;
    end

    // ---------------- instance B: INTERVAL=0, always-ready slave ----------------
    logic start_b = 0, stop_b = 0, loop_b = 0;
    logic busy_b, done_b, err_b;
    logic [31:0] value_b;
    led_axi_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
    led_axi_sequencer #(.TARGET_ADDR(32'h0), .PATTERN_LAST(32'd15), .INTERVAL(0)) dut_b (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .i_start(start_b), .i_stop(stop_b), .i_loop(loop_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_value(value_b),
        .m_axi(bus_b)
    );

    int naw_b = 0, nw_b = 0, nb_b = 0, ndone_b = 0, b_cyc_b = 0;
    logic bvalid_b_r = 0;
    bit prev_awv_b = 0, have_b_b = 0;
    logic [31:0] wd_b[$];
    int gaps_b[$];
    assign bus_b.awready = 1'b1;
    assign bus_b.wready  = 1'b1;
    assign bus_b.bresp   = 2'b00;
    assign bus_b.bvalid  = bvalid_b_r;

    always @(posedge clk) begin
        if (!rst_n) begin
            naw_b <= nb_b;
            nw_b <= nb_b;
            bvalid_b_r <= 1'b0;
        end else begin
            if (bus_b.awvalid) naw_b <= naw_b + 1;
            if (bus_b.wvalid) begin
                nw_b <= nw_b + 1;
                wd_b.push_back(bus_b.wdata);
            end
            if (bvalid_b_r && bus_b.bready) begin
                bvalid_b_r <= 1'b0;
                nb_b <= nb_b + 1;
            end else if (!bvalid_b_r && naw_b > nb_b && nw_b > nb_b) bvalid_b_r <= 1'b1;
        end
        if (done_b) ndone_b <= ndone_b + 1;
        if (bus_b.awvalid && !prev_awv_b && have_b_b) gaps_b.push_back(cyc - b_cyc_b);
        if (bus_b.bvalid && bus_b.bready) begin
            have_b_b <= 1;
            b_cyc_b <= cyc;
        end else if (!busy_b || (bus_b.awvalid && !prev_awv_b)) have_b_b <= 0;
        prev_awv_b <= bus_b.awvalid;
    end

    // ---------------- scenarios ----------------
    typedef struct {
        string nm;
        int    awd;
        int    wd;
        int    bd;
        int    err_at;   // write index answered with SLVERR, -1 for none
        bit    rnd;
        bit    exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic run_a(input vec_t v);
        int base, t, nerr0, done0, gap0, viol0, miss, nexp;
        bit exp_err;
        aw_dly = v.awd; w_dly = v.wd; b_dly = v.bd; rnd = v.rnd;
        err_abs = (v.err_at < 0) ? -1 : nb_a + v.err_at;
        @(negedge clk);
        base = wd_a.size(); nerr0 = nerr_a; done0 = ndone_a; gap0 = gaps_a.size(); viol0 = viol_a;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        chk({v.nm, "_busy_on"}, busy_a, 1);
        chk({v.nm, "_err_cleared"}, err_a, 0);
        t = 0;
        while (!done_a && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk({v.nm, "_done_seen"}, (t < 4000), 1);
        exp_err = v.rnd ? (nerr_a > nerr0) : v.exp_err;
        chk({v.nm, "_err"}, err_a, exp_err);
        chk({v.nm, "_busy_off"}, busy_a, 0);
        chk({v.nm, "_last_value"}, value_a, LAST);
        @(negedge clk);
        chk({v.nm, "_done_count"}, ndone_a - done0, 1);
        chk({v.nm, "_err_sticky"}, err_a, exp_err);
        nexp = LAST + 1;
        chk({v.nm, "_writes"}, wd_a.size() - base, nexp);
        miss = 0;
        for (int i = 0; i < nexp && base + i < wd_a.size(); i++)
            if (wd_a[base + i] !== 32'(i)) miss++;
        chk({v.nm, "_data_seq"}, miss, 0);
        chk({v.nm, "_gap_count"}, gaps_a.size() - gap0, nexp - 1);
        miss = 0;
        for (int i = gap0; i < gaps_a.size(); i++) if (gaps_a[i] != GAP_A) miss++;
        chk({v.nm, "_gap_len"}, miss, 0);
        chk({v.nm, "_protocol"}, viol_a - viol0, 0);
    endtask

    initial begin : main
        int t, base, done0, n_at_stop, miss, awv_seen;
        vecs.push_back('{"ready",     0, 0, 0, -1, 0, 0});
        vecs.push_back('{"aw_late",   3, 0, 0, -1, 0, 0});
        vecs.push_back('{"w_late",    0, 3, 0, -1, 0, 0});
        vecs.push_back('{"b_err3",    0, 0, 5,  3, 0, 1});
        vecs.push_back('{"after_err", 1, 2, 1, -1, 0, 0});
        vecs.push_back('{"err_last",  2, 1, 1, 15, 0, 1});
        for (int r = 0; r < 4; r++) vecs.push_back('{$sformatf("rand%0d", r), 0, 0, 0, -1, 1, 0});

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_value", value_a, 0);
        chk("rst_awvalid", bus_a.awvalid, 0);
        chk("rst_wvalid", bus_a.wvalid, 0);
        chk("rst_bready", bus_a.bready, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_a(vecs[i]);
        rnd = 0; aw_dly = 0; w_dly = 0; b_dly = 0; err_abs = -1;

        // stop while idling between writes
        @(negedge clk);
        base = wd_a.size(); done0 = ndone_a;
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        t = 0;
        while (!(busy_a && !bus_a.awvalid && !bus_a.wvalid && !bus_a.bready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_reached", (t < 100), 1);
        stop_a = 1;
        @(negedge clk);
        stop_a = 0;
        chk("wait_stop_busy", busy_a, 0);
        chk("wait_stop_done", done_a, 1);
        awv_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.awvalid) awv_seen++;
        end
        chk("wait_stop_no_aw", awv_seen, 0);
        chk("wait_stop_writes", wd_a.size() - base, 1);
        chk("wait_stop_done_count", ndone_a - done0, 1);

        // start and stop together: one write, then back to idle
        base = wd_a.size(); done0 = ndone_a;
        start_a = 1; stop_a = 1;
        @(negedge clk);
        start_a = 0;
        chk("start_stop_busy", busy_a, 1);
        t = 0;
        while (!done_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        stop_a = 0;
        chk("start_stop_done_seen", (t < 200), 1);
        @(negedge clk);
        chk("start_stop_writes", wd_a.size() - base, 1);
        chk("start_stop_done_count", ndone_a - done0, 1);

        // reset while both VALIDs are held on write 3
        aw_dly = 6; w_dly = 6;
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        t = 0;
        while (!(value_a == 32'd3 && bus_a.awvalid && bus_a.wvalid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reached", (t < 400), 1);
        #1 rst_n = 0;
        #1;
        chk("rst_mid_awvalid", bus_a.awvalid, 0);
        chk("rst_mid_wvalid", bus_a.wvalid, 0);
        chk("rst_mid_bready", bus_a.bready, 0);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_value", value_a, 0);
        @(negedge clk);
        rst_n = 1;
        aw_dly = 0; w_dly = 0;
        awv_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_a.awvalid || busy_a) awv_seen++;
        end
        chk("rst_mid_stays_idle", awv_seen, 0);
        run_a(vecs[0]);

        // looping with INTERVAL=0, stopped in the middle of a transfer
        @(negedge clk);
        loop_b = 1; start_b = 1;
        @(negedge clk);
        start_b = 0;
        t = 0;
        while (wd_b.size() < 20 && t < 500) begin
            @(negedge clk);
            t++;
        end
        while (!bus_b.awvalid && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("loop_reached", (t < 500), 1);
        n_at_stop = wd_b.size();
        stop_b = 1;
        t = 0;
        while (!done_b && t < 50) begin
            @(negedge clk);
            t++;
        end
        stop_b = 0;
        chk("loop_done_seen", (t < 50), 1);
        @(negedge clk);
        chk("loop_stop_writes", wd_b.size(), n_at_stop + 1);
        miss = 0;
        foreach (wd_b[i]) if (wd_b[i] !== 32'(i % (LAST + 1))) miss++;
        chk("loop_data_wrap", miss, 0);
        chk("loop_gap_count", gaps_b.size(), wd_b.size() - 1);
        miss = 0;
        foreach (gaps_b[i]) if (gaps_b[i] != GAP_B) miss++;
        chk("loop_back_to_back", miss, 0);
        chk("loop_done_count", ndone_b, 1);
        chk("loop_busy_off", busy_b, 0);
        chk("loop_err", err_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/led_axi_sequencer.md
Name: led_axi_sequencer

Overview:
AXI4-Lite write-only master that drives the myLED slave register file. On start it writes an incrementing pattern (0..PATTERN_LAST) to TARGET_ADDR, one complete AW/W/B transaction per step, separated by a programmable idle interval. It supports one-shot or looping operation, a graceful stop, and sticky error reporting of slave responses. It sits between simple control logic (buttons/PS GPIO) and the LED IP's S00_AXI port.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32; WSTRB is 4 bits)
TARGET_ADDR, 32'h0, write address (slv_reg0)
PATTERN_LAST, 15, last pattern value before completion or wrap
INTERVAL, 100, idle cycles between the end of one B handshake and the next AW/W assertion (0 allowed)

Ports:
M_AXI_ACLK  in  1  clock, all logic on rising edge
M_AXI_ARESETN  in  1  asynchronous active-low reset
i_start  in  1  level; sampled only in IDLE
i_stop  in  1  level; requests end after the current transaction
i_loop  in  1  1 = wrap to 0 after PATTERN_LAST; sampled at each step boundary
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when the FSM returns to IDLE
o_err  out  1  sticky: any BRESP != OKAY since the last start
o_value  out  32  value of the current or last written pattern
M_AXI_AWADDR  out  ADDR_W  TARGET_ADDR, held constant
M_AXI_AWPROT  out  3  constant 0
M_AXI_AWVALID  out  1  address valid
M_AXI_AWREADY  in  1  slave address ready
M_AXI_WDATA  out  32  equals o_value
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WVALID  out  1  data valid
M_AXI_WREADY  in  1  slave data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  response valid
M_AXI_BREADY  out  1  master ready for response

Behaviour:
- Reset (async, immediate): state IDLE; AWVALID, WVALID, BREADY, o_busy, o_done, o_err = 0; o_value = 0; interval counter = 0. Reset mid-transaction drops all VALID/READY outputs at once, with no completion.
- FSM states: IDLE, XFER, RESP, WAIT.
- IDLE: if i_start=1, then on the next edge clear o_err, set o_value=0, and go to XFER.
- XFER: on entry, AWVALID=WVALID=1 in the same cycle.
  - Each VALID is held until its own VALID&&READY is seen at a rising edge, then cleared on that edge. Channels complete independently, in either order or together.
  - Once both handshakes are done, go to RESP with BREADY=1. RESP is entered on the edge of the second handshake, or the same edge if both complete together.
  - A VALID is never withdrawn before its handshake.
- RESP: BREADY=1 until BVALID&&BREADY at an edge. On that edge:
  - BREADY cleared.
  - o_err |= (BRESP != 2'b00).
  - Next state decided:
    - If i_stop=1, or (o_value==PATTERN_LAST and i_loop=0): go to IDLE and pulse o_done for one cycle.
    - Else if INTERVAL==0: go directly to XFER with the next value.
    - Else: go to WAIT with counter=INTERVAL-1.
- WAIT: counter decrements each cycle. When counter==0, go to XFER with the next value on that edge, giving exactly INTERVAL WAIT cycles. i_stop=1 in WAIT goes to IDLE on the next edge and pulses o_done.
- Next value: o_value+1, or 0 when o_value==PATTERN_LAST (loop only). It is updated on the edge entering XFER, so WDATA is stable for the whole XFER.
- i_stop during XFER/RESP never aborts the AXI transaction; the stop takes effect at the B handshake.
- i_start outside IDLE is ignored. i_start and i_stop both high in IDLE: start wins, and the stop is honoured at the first B handshake.
- No read channel. No outstanding transactions beyond one.
- o_busy = (state != IDLE), registered with the state.

Test Plan:
- Slave always ready, INTERVAL=2, i_loop=0, i_start pulse: exactly 16 writes with WDATA 0..15 to addr 0; 2 idle cycles between each B handshake and the next AWVALID; o_done pulses once; o_busy falls; LED o_LED = 4'hF.
- AWREADY delayed 3 cycles after WREADY, then the reverse order: WVALID drops after its handshake while AWVALID is held; BREADY only rises after both handshakes; no duplicate writes.
- BVALID delayed 5 cycles, BRESP=2'b10 on write 3: o_err rises and stays high through the end; the sequence still completes; the next i_start clears o_err.
- i_loop=1, INTERVAL=0: after value 15 the next write is 0; back-to-back transactions with no WAIT cycles; i_stop raised mid-XFER ends after that B handshake with a single o_done.
- i_stop during WAIT: return to IDLE within 1 cycle, no further AWVALID.
- ARESETN asserted while AWVALID=1 and WVALID=1: all outputs 0 immediately; after release, idle until i_start, then restart at value 0.
